// File: rtl/minhash_pkg.sv
// minhash_pkg: shared constants and types for the MinHash signature engine
package minhash_pkg;
    localparam logic [31:0] MURMUR_C1 = 32'hcc9e2d51;
    localparam logic [31:0] MURMUR_C2 = 32'h1b873593;
    localparam logic [31:0] MURMUR_N  = 32'he6546b64;
    localparam logic [31:0] MURMUR_M  = 32'd5;
    typedef logic [31:0] hash_t;
    typedef enum logic [1:0] {ACCEPT, HASH, OUT} state_e;
endpackage

// File: rtl/murmur3_32_core.sv
// murmur3_32_core: combinational single-block MurmurHash3-32 of one k-mer under one seed
module murmur3_32_core
    import minhash_pkg::*;
(
    input  hash_t seed,
    input  hash_t kmer,
    output hash_t hash
);
    hash_t k1, k2, k3, h1, h2;
    assign k1   = kmer * MURMUR_C1;
    assign k2   = {k1[16:0], k1[31:17]};
    assign k3   = k2 * MURMUR_C2;
    assign h1   = seed ^ k3;
    assign h2   = {h1[18:0], h1[31:19]};
    assign hash = h2 * MURMUR_M + MURMUR_N;
endmodule

// File: rtl/minhash_sig_engine.sv
// minhash_sig_engine: streaming MinHash signature generator, LANES hashes per cycle
module minhash_sig_engine
    import minhash_pkg::*;
#(
    parameter int          HASHER_DATA_BITS = 32,
    parameter int          NUM_SEEDS        = 8,
    parameter int          LANES            = 2,
    parameter logic [31:0] SEED_BASE        = 32'h0,
    parameter logic [31:0] SEED_STRIDE      = 32'h1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [HASHER_DATA_BITS-1:0]           in_kmer,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NUM_SEEDS*HASHER_DATA_BITS-1:0] out_sig,
    output logic [31:0]                           out_count
);
    localparam int PASSES = NUM_SEEDS / LANES;
    localparam int PW     = PASSES > 1 ? $clog2(PASSES) : 1;

    if ((NUM_SEEDS % LANES) != 0 || HASHER_DATA_BITS != 32) begin : g_bad_params
        $error("minhash_sig_engine: NUM_SEEDS must be a multiple of LANES and width must be 32");
    end

    state_e        state, state_n;
    logic [PW-1:0] pass;
    logic          pass_last;
    hash_t         kmer_q;
    logic          last_q;
    logic          first;
    logic [31:0]   count;
    hash_t         mins [NUM_SEEDS];
    hash_t         lane_hash [LANES];

    assign pass_last = pass == PW'(PASSES - 1);
    assign out_count = count;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        hash_t seed;
        assign seed = SEED_BASE + (32'(pass) * 32'(LANES) + 32'(j)) * SEED_STRIDE;
        murmur3_32_core u_core (.seed(seed), .kmer(kmer_q), .hash(lane_hash[j]));
    end

    for (genvar i = 0; i < NUM_SEEDS; i++) begin : g_sig
        assign out_sig[i*32 +: 32] = mins[i];
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACCEPT;
        else        state <= state_n;
    end

    // next state and handshake outputs
    always_comb begin
        in_ready  = state == ACCEPT;
        out_valid = state == OUT;
        state_n   = state == ACCEPT ? (in_valid ? HASH : ACCEPT) :
                    state == HASH   ? (pass_last ? (last_q ? OUT : ACCEPT) : HASH) :
                                      (out_ready ? ACCEPT : OUT);
    end

    // k-mer latch, pass counter, k-mer count and running minima
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass   <= '0;
            kmer_q <= '0;
            last_q <= 1'b0;
            first  <= 1'b1;
            count  <= '0;
            for (int i = 0; i < NUM_SEEDS; i++) mins[i] <= '0;
        end else begin
            if (state == ACCEPT && in_valid) begin
                kmer_q <= in_kmer;
                last_q <= in_last;
                pass   <= '0;
                count  <= first ? 32'd1 : (&count ? count : count + 32'd1);
            end
            if (state == HASH) begin
                for (int i = 0; i < NUM_SEEDS; i++)
                    if (i / LANES == int'(pass))
                        mins[i] <= (first || lane_hash[i % LANES] < mins[i]) ? lane_hash[i % LANES] : mins[i];
                pass <= pass + PW'(1);
                if (pass_last) first <= 1'b0;
            end
            if (state == OUT && out_ready) first <= 1'b1;
        end
    end
endmodule

// File: tb/tb_minhash_sig_engine.sv
// tb_minhash_sig_engine: directed self-checking bench for the MinHash engine
module tb_minhash_sig_engine;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid = 0;
    logic [31:0]  in_kmer = '0;
    logic         in_last = 0;
    logic         out_ready = 0;
    logic         in_ready, out_valid, in_ready8, out_valid8;
    logic [255:0] out_sig, out_sig8;
    logic [31:0]  out_count, out_count8;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    minhash_sig_engine dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_kmer(in_kmer), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sig(out_sig), .out_count(out_count)
    );

    minhash_sig_engine #(.LANES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .in_kmer(in_kmer), .in_last(in_last), .out_valid(out_valid8),
        .out_ready(out_ready), .out_sig(out_sig8), .out_count(out_count8)
    );

    function automatic logic [31:0] mm(input logic [31:0] seed, input logic [31:0] kmer);
        logic [31:0] k, h;
        k = kmer * 32'hcc9e2d51;
        k = (k << 15) | (k >> 17);
        k = k * 32'h1b873593;
        h = seed ^ k;
        h = (h << 13) | (h >> 19);
        return h * 32'd5 + 32'he6546b64;
    endfunction

    function automatic logic [255:0] sig_of(input logic [31:0] k0, input logic [31:0] k1, input logic [31:0] k2, input int n);
        logic [255:0] s;
        logic [31:0]  m, h;
        for (int i = 0; i < 8; i++) begin
            m = mm(32'(i), k0);
            h = mm(32'(i), k1);
            if (n > 1 && h < m) m = h;
            h = mm(32'(i), k2);
            if (n > 2 && h < m) m = h;
            s[i*32 +: 32] = m;
        end
        return s;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] k, input logic l);
        int n = 0;
        while (!in_ready && n < 50) begin
            step;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%0b need 1", in_ready);
        end
        in_valid = 1;
        in_kmer  = k;
        in_last  = l;
        step;
        in_valid = 0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            step;
            cyc++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_timeout out_valid=%0b need 1", out_valid);
        end
    endtask

    task automatic check_sig(input string name, input logic [255:0] got, input logic [255:0] exp);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i*32 +: 32] !== exp[i*32 +: 32]) begin
                errors++;
                $display("FAIL %s lane %0d got %h need %h", name, i, got[i*32 +: 32], exp[i*32 +: 32]);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        step;
        step;
        checks += 4;
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b need 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b need 0", out_valid); end
        if (out_sig !== '0)     begin errors++; $display("FAIL reset_out_sig got %h need 0", out_sig); end
        if (out_count !== 0)    begin errors++; $display("FAIL reset_out_count got %0d need 0", out_count); end
        rst_n = 1;
    endtask

    task automatic test_single;
        int cyc;
        out_ready = 0;
        send(32'h0, 1);
        wait_out(cyc);
        checks += 4;
        if (cyc !== 4) begin errors++; $display("FAIL single_latency got %0d need 4", cyc); end
        if (out_sig[31:0] !== 32'he6546b64)  begin errors++; $display("FAIL single_sig0 got %h need e6546b64", out_sig[31:0]); end
        if (out_sig[63:32] !== 32'he6550b64) begin errors++; $display("FAIL single_sig1 got %h need e6550b64", out_sig[63:32]); end
        if (out_count !== 1) begin errors++; $display("FAIL single_count got %0d need 1", out_count); end
        check_sig("single_sig", out_sig, sig_of(32'h0, 32'h0, 32'h0, 1));
        out_ready = 1;
        step;
        out_ready = 0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_release got %b need 0", out_valid); end
    endtask

    task automatic test_seq_and_stall;
        int cyc;
        int n = 0;
        logic [255:0] held;
        send(32'h12345678, 0);
        while (!in_ready && n < 50) begin
            step;
            n++;
        end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL throughput_gap got %0d need 4", n); end
        send(32'hdeadbeef, 0);
        send(32'h0badf00d, 1);
        wait_out(cyc);
        check_sig("seq3_sig", out_sig, sig_of(32'h12345678, 32'hdeadbeef, 32'h0badf00d, 3));
        checks++;
        if (out_count !== 3) begin errors++; $display("FAIL seq3_count got %0d need 3", out_count); end
        held = sig_of(32'h12345678, 32'hdeadbeef, 32'h0badf00d, 3);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_kmer  = 32'h1000 + 32'(c);
            in_last  = 1;
            step;
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %b need 1", c, out_valid); end
            if (in_ready !== 1'b0)  begin errors++; $display("FAIL stall_in_ready cyc %0d got %b need 0", c, in_ready); end
            if (out_sig !== held)   begin errors++; $display("FAIL stall_sig cyc %0d got %h need %h", c, out_sig, held); end
        end
        in_valid = 0;
        checks++;
        if (out_count !== 3) begin errors++; $display("FAIL stall_count got %0d need 3", out_count); end
        out_ready = 1;
        step;
        out_ready = 0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %b need 0", out_valid); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL stall_release_ready got %b need 1", in_ready); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        out_ready = 1;
        send(32'h0, 0);
        send(32'h11111111, 1);
        wait_out(cyc);
        check_sig("b2b_first", out_sig, sig_of(32'h0, 32'h11111111, 32'h0, 2));
        checks++;
        if (out_count !== 2) begin errors++; $display("FAIL b2b_first_count got %0d need 2", out_count); end
        step;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_one_cycle got %b need 0", out_valid); end
        send(32'hcafebabe, 1);
        wait_out(cyc);
        check_sig("b2b_second", out_sig, sig_of(32'hcafebabe, 32'h0, 32'h0, 1));
        checks++;
        if (out_count !== 1) begin errors++; $display("FAIL b2b_second_count got %0d need 1", out_count); end
        step;
        out_ready = 0;
    endtask

    task automatic test_reset_mid;
        int cyc;
        send(32'h0000abcd, 0);
        send(32'h00000001, 0);
        step;
        rst_n = 0;
        step;
        rst_n = 1;
        checks += 2;
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL midreset_in_ready got %b need 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b need 0", out_valid); end
        send(32'h00000077, 1);
        wait_out(cyc);
        check_sig("midreset_sig", out_sig, sig_of(32'h77, 32'h0, 32'h0, 1));
        checks++;
        if (out_count !== 1) begin errors++; $display("FAIL midreset_count got %0d need 1", out_count); end
        out_ready = 1;
        step;
        out_ready = 0;
    endtask

    task automatic test_lanes8;
        rst_n = 0;
        step;
        step;
        rst_n = 1;
        in_valid = 1;
        in_kmer  = 32'h12345678;
        in_last  = 0;
        step;
        checks++;
        if (in_ready8 !== 1'b0) begin errors++; $display("FAIL l8_busy got %b need 0", in_ready8); end
        in_kmer = 32'h0badf00d;
        in_last = 1;
        step;
        checks++;
        if (in_ready8 !== 1'b1) begin errors++; $display("FAIL l8_rate got %b need 1", in_ready8); end
        step;
        in_valid = 0;
        step;
        checks += 2;
        if (out_valid8 !== 1'b1) begin errors++; $display("FAIL l8_latency got %b need 1", out_valid8); end
        if (out_count8 !== 2)    begin errors++; $display("FAIL l8_count got %0d need 2", out_count8); end
        check_sig("l8_sig", out_sig8, sig_of(32'h12345678, 32'h0badf00d, 32'h0, 2));
        out_ready = 1;
        step;
        out_ready = 0;
        checks++;
        if (out_valid8 !== 1'b0) begin errors++; $display("FAIL l8_release got %b need 0", out_valid8); end
        rst_n = 0;
        step;
        rst_n = 1;
    endtask

    initial begin
        test_reset;
        test_single;
        test_seq_and_stall;
        test_back_to_back;
        test_reset_mid;
        test_lanes8;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
